// File: rtl/idma_pkg.sv
`default_nettype none
// ============================================================================
// Package     : idma_pkg
// Description : Shared AXI encodings and helpers for the iDMA write channel.
// Revision    : 1.0 - initial release
// ============================================================================
package idma_pkg;

   // AXI response encodings
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // AXI burst type encoding
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   // awsize value for a data bus of the given bit width
   function automatic int unsigned clog2_bytes(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/idma_len_fifo.sv
`default_nettype none
// ============================================================================
// Module      : idma_len_fifo
// Description : Small synchronous FIFO holding awlen values of issued bursts
//               so the W path knows where each burst ends. Push and pop in
//               the same cycle are legal even when the FIFO is full.
// Revision    : 1.0 - initial release
// ============================================================================
module idma_len_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_PW:0]    r_wptr;
   logic [c_PW:0]    r_rptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer bit distinguishes full from empty
   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[c_PW] != r_rptr[c_PW]) &&
                      (r_wptr[c_PW-1:0] == r_rptr[c_PW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = r_mem[r_rptr[c_PW-1:0]];

   // Pointer update
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage write; contents are only meaningful between push and pop
   always_ff @(posedge aclk) begin
      if (w_do_push) r_mem[r_wptr[c_PW-1:0]] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/idma_wr_burst_engine.sv
`default_nettype none
// ============================================================================
// Module      : idma_wr_burst_engine
// Description : AXI4 write burst engine. Splits one {addr, beats} command
//               into INCR bursts (max length, optional 4KB split, outstanding
//               limit, optional data-level AW hold), sequences W beats from
//               the data FIFO and tracks B responses.
// Revision    : 1.0 - initial release
// ============================================================================
module idma_wr_burst_engine
   import idma_pkg::*;
#(
   parameter int DATA_W   = 256,
   parameter int ADDR_W   = 32,
   parameter int ID_W     = 4,
   parameter int AXI_ID   = 0,
   parameter int LEN_W    = 8,
   parameter int NUM_W    = 32,
   parameter int LVL_W    = 7,
   parameter int OUTSTD_W = 5,
   parameter int LQ_DEPTH = 8
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                i_cfg_init,
   input  logic [LEN_W-1:0]    i_cfg_max_len,
   input  logic [OUTSTD_W-1:0] i_cfg_max_outstd,
   input  logic                i_cfg_split4k_en,
   input  logic                i_cfg_aw_hold_en,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic [ADDR_W-1:0]   i_cmd_addr,
   input  logic [NUM_W-1:0]    i_cmd_num,
   input  logic                i_wd_valid,
   output logic                o_wd_ready,
   input  logic [DATA_W-1:0]   i_wd_data,
   input  logic [DATA_W/8-1:0] i_wd_strb,
   input  logic [LVL_W-1:0]    i_wd_level,
   output logic                o_awvalid,
   input  logic                i_awready,
   output logic [ID_W-1:0]     o_awid,
   output logic [ADDR_W-1:0]   o_awaddr,
   output logic [LEN_W-1:0]    o_awlen,
   output logic [2:0]          o_awsize,
   output logic [1:0]          o_awburst,
   output logic                o_wvalid,
   input  logic                i_wready,
   output logic [DATA_W-1:0]   o_wdata,
   output logic [DATA_W/8-1:0] o_wstrb,
   output logic                o_wlast,
   input  logic                i_bvalid,
   output logic                o_bready,
   input  logic [ID_W-1:0]     i_bid,
   input  logic [1:0]          i_bresp,
   output logic                o_done,
   output logic                o_busy,
   output logic [15:0]         o_err_cnt,
   output logic [1:0]          o_err_resp
);

   localparam int unsigned      c_BPB       = DATA_W / 8;
   localparam int unsigned      c_SIZE      = clog2_bytes(DATA_W);
   localparam logic [ADDR_W-1:0] c_ADDR_MASK = ~ADDR_W'(c_BPB - 1);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_CALC  = 2'd1;
   localparam logic [1:0] c_ST_AW    = 2'd2;
   localparam logic [1:0] c_ST_DRAIN = 2'd3;

   // Registered state
   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [NUM_W-1:0]    r_rem;
   logic [LEN_W:0]      r_blen;
   logic [OUTSTD_W-1:0] r_limit;
   logic                r_hold_en;
   logic                r_awvalid;
   logic [OUTSTD_W-1:0] r_outstd;
   logic [LEN_W-1:0]    r_beat;
   logic                r_done;
   logic [15:0]         r_err_cnt;
   logic [1:0]          r_err_resp;

   // FSM decoded outputs
   logic                w_cmd_ready;
   logic                w_in_calc;
   logic                w_in_aw;
   logic                w_done_set;

   // Datapath helpers
   logic [LEN_W:0]      w_maxb;
   logic [NUM_W-1:0]    w_maxb_ext;
   logic [12:0]         w_4k_bytes;
   logic [12:0]         w_4k_beats;
   logic [NUM_W-1:0]    w_4k_ext;
   logic [NUM_W-1:0]    w_min1;
   logic [NUM_W-1:0]    w_blen_full;
   logic [NUM_W-1:0]    w_blen_ext;
   logic [LEN_W:0]      w_blen_m1;
   logic [ADDR_W-1:0]   w_addr_inc;
   logic                w_lvl_ok;
   logic                w_aw_cond;
   logic                w_cmd_hs;
   logic                w_aw_hs;
   logic                w_w_hs;
   logic                w_w_last_hs;
   logic                w_b_hs;
   logic                w_drain_ok;
   logic [LEN_W-1:0]    w_lq_head;
   logic                w_lq_full;
   logic                w_lq_empty;
   logic                w_unused;

   // ------------------------------------------------------------------
   // Burst length: min(remaining, max_len+1, beats left in the 4KB page)
   // ------------------------------------------------------------------
   assign w_maxb      = {1'b0, i_cfg_max_len} + {{LEN_W{1'b0}}, 1'b1};
   assign w_maxb_ext  = {{(NUM_W-LEN_W-1){1'b0}}, w_maxb};
   assign w_4k_bytes  = 13'h1000 - {1'b0, r_addr[11:0]};
   assign w_4k_beats  = w_4k_bytes >> c_SIZE;
   assign w_4k_ext    = {{(NUM_W-13){1'b0}}, w_4k_beats};
   assign w_min1      = (r_rem < w_maxb_ext) ? r_rem : w_maxb_ext;
   assign w_blen_full = (i_cfg_split4k_en && (w_4k_ext < w_min1)) ? w_4k_ext : w_min1;
   assign w_blen_ext  = {{(NUM_W-LEN_W-1){1'b0}}, r_blen};
   assign w_blen_m1   = r_blen - {{LEN_W{1'b0}}, 1'b1};
   assign w_addr_inc  = {{(ADDR_W-LEN_W-1){1'b0}}, r_blen} << c_SIZE;

   // AW may only be raised when the burst can be tracked and (optionally)
   // all of its data is already sitting in the upstream FIFO
   assign w_lvl_ok    = ({{(NUM_W-LVL_W){1'b0}}, i_wd_level} >= w_blen_ext);
   assign w_aw_cond   = !w_lq_full && (r_outstd < r_limit) && (!r_hold_en || w_lvl_ok);

   // Handshakes
   assign w_cmd_hs    = i_cmd_valid && w_cmd_ready;
   assign w_aw_hs     = r_awvalid && i_awready;
   assign w_w_hs      = i_wd_valid && i_wready && !w_lq_empty;
   assign w_w_last_hs = w_w_hs && o_wlast;
   assign w_b_hs      = i_bvalid;
   assign w_drain_ok  = w_lq_empty && (r_outstd == '0);

   // FSM state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= c_ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (w_cmd_hs) w_state_nxt = (i_cmd_num == '0) ? c_ST_DRAIN : c_ST_CALC;
         c_ST_CALC:  w_state_nxt = c_ST_AW;
         c_ST_AW:    if (w_aw_hs) w_state_nxt = (r_rem == w_blen_ext) ? c_ST_DRAIN : c_ST_CALC;
         c_ST_DRAIN: if (w_drain_ok) w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      w_cmd_ready = 1'b0;
      w_in_calc   = 1'b0;
      w_in_aw     = 1'b0;
      w_done_set  = 1'b0;
      case (r_state)
         c_ST_IDLE:  w_cmd_ready = 1'b1;
         c_ST_CALC:  w_in_calc   = 1'b1;
         c_ST_AW:    w_in_aw     = 1'b1;
         c_ST_DRAIN: w_done_set  = w_drain_ok;
         default:    w_cmd_ready = 1'b0;
      endcase
   end

   // Command latch, per-burst config sampling and address/remaining update
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_addr    <= '0;
         r_rem     <= '0;
         r_blen    <= '0;
         r_limit   <= '1;
         r_hold_en <= 1'b0;
      end else if (w_cmd_hs) begin
         r_addr    <= i_cmd_addr & c_ADDR_MASK;
         r_rem     <= i_cmd_num;
      end else if (w_in_calc) begin
         r_blen    <= w_blen_full[LEN_W:0];
         r_limit   <= (i_cfg_max_outstd == '0) ? '1 : i_cfg_max_outstd;
         r_hold_en <= i_cfg_aw_hold_en;
      end else if (w_aw_hs) begin
         r_addr    <= r_addr + w_addr_inc;
         r_rem     <= r_rem - w_blen_ext;
      end
   end

   // awvalid is sticky: once raised it stays up with a stable payload
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)       r_awvalid <= 1'b0;
      else if (!w_in_aw)  r_awvalid <= 1'b0;
      else if (r_awvalid) r_awvalid <= !i_awready;
      else                r_awvalid <= w_aw_cond;
   end

   // Outstanding bursts: AW adds one, B removes one
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_outstd <= '0;
      end else begin
         case ({w_aw_hs, w_b_hs})
            2'b10:   r_outstd <= r_outstd + OUTSTD_W'(1);
            2'b01:   r_outstd <= r_outstd - OUTSTD_W'(1);
            default: r_outstd <= r_outstd;
         endcase
      end
   end

   // A B response with nothing outstanding indicates a broken slave or bug
   always_ff @(posedge aclk) begin
      if (aresetn && w_b_hs && !w_aw_hs) assert (r_outstd != '0);
   end

   // W beat position inside the burst at the head of the length queue
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)         r_beat <= '0;
      else if (w_w_last_hs) r_beat <= '0;
      else if (w_w_hs)      r_beat <= r_beat + LEN_W'(1);
   end

   // One-cycle completion pulse, registered off the drain condition
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_done <= 1'b0;
      else          r_done <= w_done_set;
   end

   // Error accounting; an init pulse overrides a same-cycle error
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_err_cnt  <= '0;
         r_err_resp <= '0;
      end else if (i_cfg_init) begin
         r_err_cnt  <= '0;
         r_err_resp <= '0;
      end else if (w_b_hs && (i_bresp != AXI_RESP_OKAY)) begin
         if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
         if (r_err_resp == AXI_RESP_OKAY) r_err_resp <= i_bresp;
      end
   end

   idma_len_fifo #(
      .WIDTH (LEN_W),
      .DEPTH (LQ_DEPTH)
   ) u_len_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_push  (w_aw_hs),
      .i_data  (w_blen_m1[LEN_W-1:0]),
      .i_pop   (w_w_last_hs),
      .o_data  (w_lq_head),
      .o_full  (w_lq_full),
      .o_empty (w_lq_empty)
   );

   // Output wiring
   assign o_cmd_ready = w_cmd_ready;
   assign o_awvalid   = r_awvalid;
   assign o_awid      = ID_W'(AXI_ID);
   assign o_awaddr    = r_addr;
   assign o_awlen     = w_blen_m1[LEN_W-1:0];
   assign o_awsize    = 3'(c_SIZE);
   assign o_awburst   = AXI_BURST_INCR;
   assign o_wvalid    = i_wd_valid && !w_lq_empty;
   assign o_wd_ready  = i_wready && !w_lq_empty;
   assign o_wdata     = i_wd_data;
   assign o_wstrb     = i_wd_strb;
   assign o_wlast     = !w_lq_empty && (r_beat == w_lq_head);
   assign o_bready    = 1'b1;
   assign o_done      = r_done;
   assign o_busy      = (r_state != c_ST_IDLE) || r_done;
   assign o_err_cnt   = r_err_cnt;
   assign o_err_resp  = r_err_resp;

   // Bits with no function in this engine (bid is not checked)
   assign w_unused = ^{i_bid, w_blen_full[NUM_W-1:LEN_W+1], w_blen_m1[LEN_W]};

endmodule
`default_nettype wire

// File: tb/tb_idma_wr_burst_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_idma_wr_burst_engine
// Description : Directed self-checking bench for idma_wr_burst_engine with a
//               small AXI write slave and a handshake logger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idma_wr_burst_engine;
   import idma_pkg::*;

   localparam int DATA_W   = 256;
   localparam int ADDR_W   = 32;
   localparam int ID_W     = 4;
   localparam int LEN_W    = 8;
   localparam int NUM_W    = 32;
   localparam int LVL_W    = 7;
   localparam int OUTSTD_W = 5;

   logic                aclk = 1'b0;
   logic                aresetn = 1'b0;
   logic                cfg_init = 1'b0;
   logic [LEN_W-1:0]    cfg_max_len = 8'd15;
   logic [OUTSTD_W-1:0] cfg_max_outstd = '0;
   logic                cfg_split4k_en = 1'b0;
   logic                cfg_aw_hold_en = 1'b0;
   logic                cmd_valid = 1'b0;
   logic                cmd_ready;
   logic [ADDR_W-1:0]   cmd_addr = '0;
   logic [NUM_W-1:0]    cmd_num = '0;
   logic                wd_valid = 1'b1;
   logic                wd_ready;
   logic [DATA_W-1:0]   wd_data = '0;
   logic [DATA_W/8-1:0] wd_strb = '1;
   logic [LVL_W-1:0]    wd_level = 7'd127;
   logic                awvalid;
   logic                awready = 1'b1;
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [LEN_W-1:0]    awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                wvalid;
   logic                wready = 1'b1;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                bvalid = 1'b0;
   logic                bready;
   logic [ID_W-1:0]     bid = '0;
   logic [1:0]          bresp = 2'b00;
   logic                done;
   logic                busy;
   logic [15:0]         err_cnt;
   logic [1:0]          err_resp;

   int n_tests = 0;
   int n_fail  = 0;

   // Handshake log (written by the monitor, cleared by the stimulus)
   int               n_aw, n_wbeat, n_wlast, n_b, n_done, n_wbad;
   logic [ADDR_W-1:0] aw_addr [16];
   logic [LEN_W-1:0]  aw_len  [16];
   int               wlast_pos [16];
   logic [1:0]        resp_tab [16];
   logic              b_hold = 1'b0;

   idma_wr_burst_engine u_dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .i_cfg_init       (cfg_init),
      .i_cfg_max_len    (cfg_max_len),
      .i_cfg_max_outstd (cfg_max_outstd),
      .i_cfg_split4k_en (cfg_split4k_en),
      .i_cfg_aw_hold_en (cfg_aw_hold_en),
      .i_cmd_valid      (cmd_valid),
      .o_cmd_ready      (cmd_ready),
      .i_cmd_addr       (cmd_addr),
      .i_cmd_num        (cmd_num),
      .i_wd_valid       (wd_valid),
      .o_wd_ready       (wd_ready),
      .i_wd_data        (wd_data),
      .i_wd_strb        (wd_strb),
      .i_wd_level       (wd_level),
      .o_awvalid        (awvalid),
      .i_awready        (awready),
      .o_awid           (awid),
      .o_awaddr         (awaddr),
      .o_awlen          (awlen),
      .o_awsize         (awsize),
      .o_awburst        (awburst),
      .o_wvalid         (wvalid),
      .i_wready         (wready),
      .o_wdata          (wdata),
      .o_wstrb          (wstrb),
      .o_wlast          (wlast),
      .i_bvalid         (bvalid),
      .o_bready         (bready),
      .i_bid            (bid),
      .i_bresp          (bresp),
      .o_done           (done),
      .o_busy           (busy),
      .o_err_cnt        (err_cnt),
      .o_err_resp       (err_resp)
   );

   always #5 aclk = ~aclk;

   // Monitor: handshakes that will complete at the coming rising edge
   always @(negedge aclk) begin
      if (aresetn) begin
         if (awvalid && awready) begin
            if (n_aw < 16) begin
               aw_addr[n_aw] = awaddr;
               aw_len[n_aw]  = awlen;
            end
            n_aw++;
         end
         if (wvalid && wready) begin
            n_wbeat++;
            if (wdata !== wd_data || wstrb !== wd_strb) n_wbad++;
            if (wlast) begin
               if (n_wlast < 16) wlast_pos[n_wlast] = n_wbeat;
               n_wlast++;
            end
         end
         if (bvalid && bready) n_b++;
         if (done) n_done++;
      end
   end

   // B responder: one response per completed W burst, optionally held off
   always @(posedge aclk) begin
      #1;
      if (!aresetn) begin
         bvalid = 1'b0;
      end else begin
         bvalid = !b_hold && (n_wlast > n_b);
         bresp  = (n_b < 16) ? resp_tab[n_b] : AXI_RESP_OKAY;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic sample();
      @(negedge aclk);
      #1;
   endtask

   task automatic clear_log();
      n_aw = 0; n_wbeat = 0; n_wlast = 0; n_b = 0; n_done = 0; n_wbad = 0;
      for (int i = 0; i < 16; i++) resp_tab[i] = AXI_RESP_OKAY;
   endtask

   task automatic issue(input logic [ADDR_W-1:0] a, input logic [NUM_W-1:0] n);
      clear_log();
      wd_data  = {8{$urandom()}};
      wd_strb  = $urandom();
      cmd_addr = a;
      cmd_num  = n;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (n_done == 0 && k < budget) begin
         sample();
         k++;
      end
      chk(tag, 64'(n_done != 0), 64'd1);
      repeat (4) step();
   endtask

   initial begin
      clear_log();
      repeat (3) step();
      aresetn = 1'b1;

      // Reset state
      sample();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_awvalid",   64'(awvalid),   64'd0);
      chk("rst_wvalid",    64'(wvalid),    64'd0);
      chk("rst_done",      64'(done),      64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_bready",    64'(bready),    64'd1);
      chk("rst_err_cnt",   64'(err_cnt),   64'd0);
      chk("rst_err_resp",  64'(err_resp),  64'd0);
      chk("awsize",        64'(awsize),    64'd5);
      chk("awburst",       64'(awburst),   64'd1);
      chk("awid",          64'(awid),      64'd0);
      step();

      // Single 16-beat burst
      issue(32'h0, 32'd16);
      sample();
      chk("t1_busy", 64'(busy), 64'd1);
      wait_done("t1_done_seen", 200);
      chk("t1_n_aw",    64'(n_aw),         64'd1);
      chk("t1_awaddr",  64'(aw_addr[0]),   64'h0);
      chk("t1_awlen",   64'(aw_len[0]),    64'd15);
      chk("t1_beats",   64'(n_wbeat),      64'd16);
      chk("t1_n_wlast", 64'(n_wlast),      64'd1);
      chk("t1_wlast_at",64'(wlast_pos[0]), 64'd16);
      chk("t1_n_b",     64'(n_b),          64'd1);
      chk("t1_n_done",  64'(n_done),       64'd1);
      chk("t1_wdata",   64'(n_wbad),       64'd0);
      chk("t1_busy_end",64'(busy),         64'd0);

      // 4KB split: 0xFC0 leaves 2 beats in the page
      cfg_split4k_en = 1'b1;
      issue(32'hFC0, 32'd8);
      wait_done("t2_done_seen", 200);
      chk("t2_n_aw",    64'(n_aw),       64'd2);
      chk("t2_addr0",   64'(aw_addr[0]), 64'hFC0);
      chk("t2_len0",    64'(aw_len[0]),  64'd1);
      chk("t2_addr1",   64'(aw_addr[1]), 64'h1000);
      chk("t2_len1",    64'(aw_len[1]),  64'd5);
      chk("t2_beats",   64'(n_wbeat),    64'd8);

      // No split, unaligned low bits dropped
      cfg_split4k_en = 1'b0;
      issue(32'hFCF, 32'd8);
      wait_done("t3_done_seen", 200);
      chk("t3_n_aw",  64'(n_aw),       64'd1);
      chk("t3_addr0", 64'(aw_addr[0]), 64'hFC0);
      chk("t3_len0",  64'(aw_len[0]),  64'd7);

      // Outstanding limit with B held off
      cfg_split4k_en = 1'b1;
      cfg_max_len    = 8'd7;
      cfg_max_outstd = 5'd2;
      b_hold         = 1'b1;
      issue(32'h2000, 32'd64);
      repeat (60) step();
      sample();
      chk("t4_aw_held", 64'(n_aw),   64'd2);
      chk("t4_no_b",    64'(n_b),    64'd0);
      chk("t4_no_done", 64'(n_done), 64'd0);
      step();
      b_hold = 1'b0;
      wait_done("t4_done_seen", 400);
      chk("t4_n_aw",   64'(n_aw),       64'd8);
      chk("t4_addr7",  64'(aw_addr[7]), 64'h2700);
      chk("t4_len7",   64'(aw_len[7]),  64'd7);
      chk("t4_beats",  64'(n_wbeat),    64'd64);
      chk("t4_wlasts", 64'(n_wlast),    64'd8);
      chk("t4_n_b",    64'(n_b),        64'd8);
      chk("t4_n_done", 64'(n_done),     64'd1);
      cfg_max_outstd = '0;

      // AW held until the data FIFO holds the whole burst
      cfg_max_len    = 8'd15;
      cfg_aw_hold_en = 1'b1;
      wd_level       = 7'd3;
      issue(32'h4000, 32'd8);
      repeat (10) step();
      sample();
      chk("t5_aw_low",  64'(awvalid), 64'd0);
      chk("t5_no_aw",   64'(n_aw),    64'd0);
      step();
      wd_level = 7'd8;
      sample();
      chk("t5_aw_not_yet", 64'(awvalid), 64'd0);
      sample();
      chk("t5_aw_high",    64'(awvalid), 64'd1);
      wait_done("t5_done_seen", 200);
      chk("t5_len0", 64'(aw_len[0]), 64'd7);
      cfg_aw_hold_en = 1'b0;
      wd_level       = 7'd127;

      // Error responses: SLVERR on burst 2, DECERR on burst 4
      cfg_max_len = 8'd7;
      issue(32'h3000, 32'd32);
      resp_tab[1] = AXI_RESP_SLVERR;
      resp_tab[3] = AXI_RESP_DECERR;
      wait_done("t6_done_seen", 300);
      chk("t6_n_b",     64'(n_b),      64'd4);
      chk("t6_err_cnt", 64'(err_cnt),  64'd2);
      chk("t6_err_resp",64'(err_resp), 64'd2);
      cfg_init = 1'b1;
      step();
      cfg_init = 1'b0;
      sample();
      chk("t6_init_cnt",  64'(err_cnt),  64'd0);
      chk("t6_init_resp", 64'(err_resp), 64'd0);
      step();

      // Zero-beat command: done two cycles after accept, no traffic
      clear_log();
      cmd_num   = '0;
      cmd_addr  = 32'h100;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      sample();
      chk("t7_done_c1", 64'(done), 64'd0);
      chk("t7_busy_c1", 64'(busy), 64'd1);
      sample();
      chk("t7_done_c2", 64'(done), 64'd1);
      chk("t7_busy_c2", 64'(busy), 64'd1);
      sample();
      chk("t7_done_c3", 64'(done), 64'd0);
      chk("t7_busy_c3", 64'(busy), 64'd0);
      chk("t7_no_aw",   64'(n_aw),    64'd0);
      chk("t7_no_w",    64'(n_wbeat), 64'd0);
      step();

      // Asynchronous reset in the middle of a command
      b_hold = 1'b1;
      issue(32'h5000, 32'd16);
      repeat (6) step();
      aresetn = 1'b0;
      #2;
      chk("t8_rst_awvalid", 64'(awvalid),   64'd0);
      chk("t8_rst_wvalid",  64'(wvalid),    64'd0);
      chk("t8_rst_busy",    64'(busy),      64'd0);
      chk("t8_rst_ready",   64'(cmd_ready), 64'd1);
      chk("t8_rst_done",    64'(done),      64'd0);
      clear_log();
      repeat (2) step();
      aresetn = 1'b1;
      b_hold  = 1'b0;
      step();
      issue(32'h6000, 32'd4);
      wait_done("t8_done_seen", 200);
      chk("t8_n_aw",  64'(n_aw),       64'd1);
      chk("t8_addr0", 64'(aw_addr[0]), 64'h6000);
      chk("t8_len0",  64'(aw_len[0]),  64'd3);
      chk("t8_beats", 64'(n_wbeat),    64'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
